grf_mp: RTL and testbench

Parametrised multi-port general register file for the single-cycle and pipelined MIPS datapaths. It holds 2^ADDR_W registers of WIDTH bits and provides one synchronous write port and NREAD combinational read ports. Optional write-to-read bypass lets the pipelined core drop its WB→ID forwarding mux. Register 0 can be hardwired to zero. A committed-write counter supports trace comparison in simulation.

---
 rtl/grf_mp.sv | 64 ++++++
 tb/tb_grf_mp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_mp.sv
// Multi-port general register file: one synchronous write port, NREAD combinational
// read ports, optional write-to-read bypass, optional hardwired zero register.
module grf_mp #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*WIDTH-1:0]  rdata,
    output logic [CNT_W-1:0]        wr_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic             commit;

    // Writes to r0 are dropped (and not counted) when r0 is hardwired.
    always_comb commit = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
            cnt <= '0;
        end else if (commit) begin
            regs[waddr] <= wdata;
            cnt         <= cnt + CNT_W'(1);
        end
    end

    assign wr_cnt = cnt;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        // Later assignments take priority: zero register beats bypass beats storage.
        always_comb begin
            rd = regs[ra];
            if ((BYPASS != 0) && rst_n && we && (ra == waddr)) begin
                rd = wdata;
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end
        end

        assign rdata[k*WIDTH +: WIDTH] = rd;
    end

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: three differently parameterised instances checked
// every cycle against an array-based model, plus hand-computed literal expectations.
module tb_grf_mp;

    localparam int WID [3] = '{32, 32, 16};
    localparam int AW  [3] = '{5, 5, 3};
    localparam int NR  [3] = '{2, 2, 4};
    localparam int BYP [3] = '{1, 0, 1};
    localparam int ZR  [3] = '{1, 0, 1};
    localparam int CW  [3] = '{32, 8, 4};

    logic        clk;
    logic        rst_n;
    logic        we    [3];
    logic [4:0]  waddr [3];
    logic [31:0] wdata [3];
    logic [4:0]  raddr [3][4];

    logic [63:0] rd0, rd1, rd2;
    logic [31:0] cnt0;
    logic [7:0]  cnt1;
    logic [3:0]  cnt2;

    int n_checks = 0;
    int n_errors = 0;

    grf_mp #(.WIDTH(32), .ADDR_W(5), .NREAD(2), .BYPASS(1), .ZERO_REG(1), .CNT_W(32)) u0 (
        .clk(clk), .rst_n(rst_n), .we(we[0]), .waddr(waddr[0]), .wdata(wdata[0]),
        .raddr({raddr[0][1], raddr[0][0]}), .rdata(rd0), .wr_cnt(cnt0));

    grf_mp #(.WIDTH(32), .ADDR_W(5), .NREAD(2), .BYPASS(0), .ZERO_REG(0), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we[1]), .waddr(waddr[1]), .wdata(wdata[1]),
        .raddr({raddr[1][1], raddr[1][0]}), .rdata(rd1), .wr_cnt(cnt1));

    grf_mp #(.WIDTH(16), .ADDR_W(3), .NREAD(4), .BYPASS(1), .ZERO_REG(1), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .we(we[2]), .waddr(waddr[2][2:0]), .wdata(wdata[2][15:0]),
        .raddr({raddr[2][3][2:0], raddr[2][2][2:0], raddr[2][1][2:0], raddr[2][0][2:0]}),
        .rdata(rd2), .wr_cnt(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [63:0] mem [3][32];
    logic [63:0] mcnt [3];
    bit          valid = 1'b0;

    function automatic logic [63:0] msk(int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] exp_rd(int i, int k);
        logic [63:0] a;
        a = 64'(raddr[i][k]) & msk(AW[i]);
        if (ZR[i] != 0 && a == 0) return 64'd0;
        if (BYP[i] != 0 && rst_n === 1'b1 && we[i] && a == (64'(waddr[i]) & msk(AW[i])))
            return 64'(wdata[i]) & msk(WID[i]);
        return mem[i][a];
    endfunction

    function automatic logic [63:0] act_rd(int i, int k);
        logic [63:0] v;
        case (i)
            0:       v = rd0 >> (k * 32);
            1:       v = rd1 >> (k * 32);
            default: v = rd2 >> (k * 16);
        endcase
        return v & msk(WID[i]);
    endfunction

    function automatic logic [63:0] act_cnt(int i);
        case (i)
            0:       return 64'(cnt0);
            1:       return 64'(cnt1);
            default: return 64'(cnt2);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            for (int i = 0; i < 3; i++) begin
                for (int a = 0; a < 32; a++) mem[i][a] = 64'd0;
                mcnt[i] = 64'd0;
            end
            valid = 1'b1;
        end else if (valid) begin
            for (int i = 0; i < 3; i++) begin
                logic [63:0] a;
                a = 64'(waddr[i]) & msk(AW[i]);
                if (we[i] && !(ZR[i] != 0 && a == 0)) begin
                    mem[i][a] = 64'(wdata[i]) & msk(WID[i]);
                    mcnt[i]   = (mcnt[i] + 64'd1) & msk(CW[i]);
                end
            end
        end
    end

    // Compare process: mid-cycle, inputs stable, before the next rising edge.
    always @(negedge clk) begin
        if (valid) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < NR[i]; k++)
                    chk($sformatf("u%0d_rd%0d", i, k), act_rd(i, k), exp_rd(i, k));
                chk($sformatf("u%0d_cnt", i), act_cnt(i), mcnt[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0;
            waddr[i] = '0;
            wdata[i] = '0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) raddr[i][k] = '0;
        cyc();
        rst_n = 1'b1;

        // Reset clears contents and suppresses both the write and the bypass.
        we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
        cyc();
        idle(); raddr[0][0] = 5'd5; #1;
        chk("lit_r5_written", act_rd(0, 0), 64'hDEADBEEF);
        rst_n = 1'b0;
        we[0] = 1'b1; waddr[0] = 5'd7; wdata[0] = 32'h00000077; raddr[0][1] = 5'd7; #1;
        chk("lit_no_bypass_in_reset", act_rd(0, 1), 64'd0);
        cyc();
        rst_n = 1'b1; idle(); #1;
        chk("lit_r5_after_reset", act_rd(0, 0), 64'd0);
        chk("lit_r7_after_reset", act_rd(0, 1), 64'd0);
        chk("lit_cnt_after_reset", act_cnt(0), 64'd0);

        // Basic write/read on consecutive edges.
        we[0] = 1'b1; waddr[0] = 5'd1; wdata[0] = 32'h11111111;
        cyc();
        waddr[0] = 5'd31; wdata[0] = 32'hFFFFFFFF;
        cyc();
        idle(); raddr[0][0] = 5'd1; raddr[0][1] = 5'd31; #1;
        chk("lit_r1", act_rd(0, 0), 64'h11111111);
        chk("lit_r31", act_rd(0, 1), 64'hFFFFFFFF);
        chk("lit_cnt2", act_cnt(0), 64'd2);

        // r0 write: hardwired on u0, ordinary on u1.
        for (int i = 0; i < 2; i++) begin
            we[i] = 1'b1; waddr[i] = 5'd0; wdata[i] = 32'h12345678;
        end
        cyc();
        idle();
        raddr[0][0] = 5'd0; raddr[0][1] = 5'd0; raddr[1][0] = 5'd0; #1;
        chk("lit_zr_p0", act_rd(0, 0), 64'd0);
        chk("lit_zr_p1", act_rd(0, 1), 64'd0);
        chk("lit_zr_cnt", act_cnt(0), 64'd2);
        chk("lit_nozr_r0", act_rd(1, 0), 64'h12345678);
        chk("lit_nozr_cnt", act_cnt(1), 64'd1);

        // Read during write to the same address, with and without bypass.
        for (int i = 0; i < 2; i++) begin
            we[i] = 1'b1; waddr[i] = 5'd3; wdata[i] = 32'hAAAA0000; raddr[i][0] = 5'd3;
        end
        cyc();
        for (int i = 0; i < 2; i++) wdata[i] = 32'h5555FFFF;
        #1;
        chk("lit_byp_new", act_rd(0, 0), 64'h5555FFFF);
        chk("lit_nobyp_old", act_rd(1, 0), 64'hAAAA0000);
        cyc();
        idle(); #1;
        chk("lit_nobyp_after", act_rd(1, 0), 64'h5555FFFF);
        rst_n = 1'b0;
        we[0] = 1'b1; waddr[0] = 5'd3; wdata[0] = 32'h12121212; #1;
        chk("lit_byp_held_in_reset", act_rd(0, 0), 64'h5555FFFF);
        cyc();
        rst_n = 1'b1; idle();

        // Counter wrap on the 4-bit instance, r0 writes interleaved and uncounted.
        for (int n = 1; n <= 17; n++) begin
            we[2] = 1'b1; waddr[2] = 5'((n % 7) + 1); wdata[2] = $urandom;
            cyc();
            chk("lit_cnt_wrap", act_cnt(2), 64'(n % 16));
            waddr[2] = 5'd0; wdata[2] = $urandom;
            cyc();
            chk("lit_cnt_r0_skip", act_cnt(2), 64'(n % 16));
        end

        // Multi-port: reg[i] = i*0x0101, then distinct and identical addresses.
        for (int i = 1; i < 8; i++) begin
            we[2] = 1'b1; waddr[2] = 5'(i); wdata[2] = 32'(i * 32'h0101);
            cyc();
        end
        idle();
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 4; k++)
                raddr[2][k] = (c % 2 == 0) ? 5'((c + k) % 8) : 5'(c);
            cyc();
        end
        for (int k = 0; k < 4; k++) raddr[2][k] = 5'd5;
        #1;
        for (int k = 0; k < 4; k++) chk("lit_mp_r5", act_rd(2, k), 64'h0505);

        // Randomised traffic with occasional reset and forced address collisions.
        for (int t = 0; t < 400; t++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < 3; i++) begin
                we[i]    = $urandom_range(0, 2) != 0;
                waddr[i] = 5'($urandom);
                wdata[i] = $urandom;
                for (int k = 0; k < 4; k++) raddr[i][k] = 5'($urandom);
                if ($urandom_range(0, 2) == 0) raddr[i][0] = waddr[i];
                if ($urandom_range(0, 5) == 0) waddr[i] = 5'd0;
            end
            cyc();
        end
        rst_n = 1'b1; idle();
        cyc();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
